// File: rtl/reflet_float_au_arbiter.sv
// Shares one reflet_float_au between two requesters: latches the winner's op, runs the AU, returns result/done.
// Latency: acceptance edge to done = (cycles until au_ready) + 1; one op outstanding. Backpressure: ack only in IDLE.
// Optional REFLET_FPU_ARB_FIXED_PRIORITY_EN: req0 always wins ties (default is round-robin).
module reflet_float_au_arbiter #(
    parameter int float_size     = 32,
    parameter int timeout_cycles = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [5:0]            req0_opcode,
    input  logic [float_size-1:0] req0_in1,
    input  logic [float_size-1:0] req0_in2,
    input  logic [float_size-1:0] req0_in3,
    output logic                  req0_ack,
    output logic                  req0_done,
    output logic                  req0_timeout,
    output logic [float_size-1:0] req0_result,
    input  logic                  req1_valid,
    input  logic [5:0]            req1_opcode,
    input  logic [float_size-1:0] req1_in1,
    input  logic [float_size-1:0] req1_in2,
    input  logic [float_size-1:0] req1_in3,
    output logic                  req1_ack,
    output logic                  req1_done,
    output logic                  req1_timeout,
    output logic [float_size-1:0] req1_result,
    output logic                  au_enable,
    output logic [5:0]            au_opcode,
    output logic [float_size-1:0] au_in1,
    output logic [float_size-1:0] au_in2,
    output logic [float_size-1:0] au_in3,
    input  logic                  au_ready,
    input  logic [float_size-1:0] au_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [15:0] CNT_LAST = 16'(timeout_cycles - 1);

    state_t      state;
    logic        last_grant;
    logic        owner;
    logic        grant;
    logic        accept;
    logic [15:0] cnt;

    always_comb begin
        grant = 1'b0;
`ifdef REFLET_FPU_ARB_FIXED_PRIORITY_EN
        grant = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid & ~req0_valid;
`endif
    end

    assign req0_ack = (state == IDLE) && !grant && req0_valid;
    assign req1_ack = (state == IDLE) &&  grant && req1_valid;
    assign accept   = req0_ack | req1_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            au_enable    <= 1'b0;
            au_opcode    <= '0;
            au_in1       <= '0;
            au_in2       <= '0;
            au_in3       <= '0;
            req0_done    <= 1'b0;
            req0_timeout <= 1'b0;
            req0_result  <= '0;
            req1_done    <= 1'b0;
            req1_timeout <= 1'b0;
            req1_result  <= '0;
        end else begin
            req0_done    <= 1'b0;
            req0_timeout <= 1'b0;
            req1_done    <= 1'b0;
            req1_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        au_opcode  <= grant ? req1_opcode : req0_opcode;
                        au_in1     <= grant ? req1_in1    : req0_in1;
                        au_in2     <= grant ? req1_in2    : req0_in2;
                        au_in3     <= grant ? req1_in3    : req0_in3;
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= '0;
                        au_enable  <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 16'd1;
                    // A ready arriving on the final allowed cycle still counts as success.
                    if (au_ready) begin
                        if (owner) begin
                            req1_result <= au_out;
                            req1_done   <= 1'b1;
                        end else begin
                            req0_result <= au_out;
                            req0_done   <= 1'b1;
                        end
                        au_enable <= 1'b0;
                        state     <= DRAIN;
                    end else if (cnt == CNT_LAST) begin
                        if (owner) begin
                            req1_result  <= '0;
                            req1_done    <= 1'b1;
                            req1_timeout <= 1'b1;
                        end else begin
                            req0_result  <= '0;
                            req0_done    <= 1'b1;
                            req0_timeout <= 1'b1;
                        end
                        au_enable <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    au_enable <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_float_au_arbiter.sv
// Directed bench for reflet_float_au_arbiter with a small behavioural AU model per instance.
module tb_reflet_float_au_arbiter;

    localparam logic [5:0] OPP_ADD = 6'h01;
    localparam logic [5:0] OPP_MUL = 6'h03;
    localparam logic [5:0] OPP_BAD = 6'h3F;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance (timeout 64)
    logic        req0_valid = 0, req1_valid = 0;
    logic [5:0]  req0_opcode = 0, req1_opcode = 0;
    logic [31:0] req0_in1 = 0, req0_in2 = 0, req0_in3 = 0;
    logic [31:0] req1_in1 = 0, req1_in2 = 0, req1_in3 = 0;
    logic        req0_ack, req0_done, req0_timeout, req1_ack, req1_done, req1_timeout;
    logic [31:0] req0_result, req1_result;
    logic        au_enable, au_ready;
    logic [5:0]  au_opcode;
    logic [31:0] au_in1, au_in2, au_in3, au_out;
    int          au_cyc;

    reflet_float_au_arbiter #(.float_size(32), .timeout_cycles(64)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_opcode(req0_opcode),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_in3(req0_in3),
        .req0_ack(req0_ack), .req0_done(req0_done), .req0_timeout(req0_timeout), .req0_result(req0_result),
        .req1_valid(req1_valid), .req1_opcode(req1_opcode),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_in3(req1_in3),
        .req1_ack(req1_ack), .req1_done(req1_done), .req1_timeout(req1_timeout), .req1_result(req1_result),
        .au_enable(au_enable), .au_opcode(au_opcode),
        .au_in1(au_in1), .au_in2(au_in2), .au_in3(au_in3),
        .au_ready(au_ready), .au_out(au_out)
    );

    // AU model: add ready in the first enabled cycle, mul in the third, anything else never.
    always_ff @(posedge clk) au_cyc <= au_enable ? au_cyc + 1 : 0;
    always_comb begin
        au_ready = au_enable && ((au_opcode == OPP_ADD) || (au_opcode == OPP_MUL && au_cyc == 2));
        au_out   = 32'h0;
        if (au_opcode == OPP_ADD && au_in1 == 32'h3FC00000 && au_in2 == 32'h40100000) au_out = 32'h40700000;
        else if (au_opcode == OPP_ADD && au_in1 == 32'h3F800000 && au_in2 == 32'h3F800000) au_out = 32'h40000000;
        else if (au_opcode == OPP_MUL && au_in1 == 32'h40000000 && au_in2 == 32'h40400000) au_out = 32'h40C00000;
    end

    // Second instance (timeout 3), only req0 used
    logic        c_valid = 0;
    logic [5:0]  c_opcode = 0;
    logic        c0_ack, c0_done, c0_timeout, c1_ack, c1_done, c1_timeout;
    logic [31:0] c0_result, c1_result;
    logic        c_en, c_ready;
    logic [5:0]  c_op;
    logic [31:0] c_in1, c_in2, c_in3;
    int          c_cyc;

    reflet_float_au_arbiter #(.float_size(32), .timeout_cycles(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(c_valid), .req0_opcode(c_opcode),
        .req0_in1(32'h1), .req0_in2(32'h2), .req0_in3(32'h3),
        .req0_ack(c0_ack), .req0_done(c0_done), .req0_timeout(c0_timeout), .req0_result(c0_result),
        .req1_valid(1'b0), .req1_opcode(6'h0),
        .req1_in1(32'h0), .req1_in2(32'h0), .req1_in3(32'h0),
        .req1_ack(c1_ack), .req1_done(c1_done), .req1_timeout(c1_timeout), .req1_result(c1_result),
        .au_enable(c_en), .au_opcode(c_op),
        .au_in1(c_in1), .au_in2(c_in2), .au_in3(c_in3),
        .au_ready(c_ready), .au_out(32'h12345678)
    );

    always_ff @(posedge clk) c_cyc <= c_en ? c_cyc + 1 : 0;
    assign c_ready = c_en && (c_op != OPP_BAD) && (c_cyc == 2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [1:0] exp_ack;
        int w;

        // Reset state
        #1;
        chk("rst_au_enable", {31'b0, au_enable}, 32'h0);
        chk("rst_au_opcode", {26'b0, au_opcode}, 32'h0);
        chk("rst_au_in1", au_in1, 32'h0);
        chk("rst_done0", {31'b0, req0_done}, 32'h0);
        chk("rst_result1", req1_result, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Add on req0
        req0_valid = 1; req0_opcode = OPP_ADD; req0_in1 = 32'h3FC00000; req0_in2 = 32'h40100000;
        #1;
        chk("add_ack0", {30'b0, req1_ack, req0_ack}, 32'h1);
        tick();
        req0_valid = 0;
        chk("add_run_en", {31'b0, au_enable}, 32'h1);
        chk("add_run_op", {26'b0, au_opcode}, {26'b0, OPP_ADD});
        chk("add_run_in2", au_in2, 32'h40100000);
        chk("add_run_done", {31'b0, req0_done}, 32'h0);
        tick();
        chk("add_done", {30'b0, req0_timeout, req0_done}, 32'h1);
        chk("add_result", req0_result, 32'h40700000);
        chk("add_drain_en", {31'b0, au_enable}, 32'h0);
        tick();
        chk("add_done_pulse", {31'b0, req0_done}, 32'h0);

        // Multiply on req1
        req1_valid = 1; req1_opcode = OPP_MUL; req1_in1 = 32'h40000000; req1_in2 = 32'h40400000;
        #1;
        chk("mul_ack1", {30'b0, req1_ack, req0_ack}, 32'h2);
        tick();
        req1_valid = 0;
        chk("mul_run1_en", {30'b0, au_enable, req1_done}, 32'h2);
        tick();
        chk("mul_run2_en", {30'b0, au_enable, req1_done}, 32'h2);
        tick();
        chk("mul_run3_en_rdy", {29'b0, au_ready, au_enable, req1_done}, 32'h6);
        tick();
        chk("mul_done", {30'b0, req1_timeout, req1_done}, 32'h1);
        chk("mul_result", req1_result, 32'h40C00000);
        chk("mul_drain_en", {31'b0, au_enable}, 32'h0);
        chk("mul_req0_done", {31'b0, req0_done}, 32'h0);
        chk("mul_req0_result", req0_result, 32'h40700000);
        tick();

        // Contention: both requesters valid with add ops
        req0_valid = 1; req0_opcode = OPP_ADD; req0_in1 = 32'h3FC00000; req0_in2 = 32'h40100000;
        req1_valid = 1; req1_opcode = OPP_ADD; req1_in1 = 32'h3F800000; req1_in2 = 32'h3F800000;
        #1;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (!(req0_ack || req1_ack) && w < 10) begin
                tick();
                w++;
            end
`ifdef REFLET_FPU_ARB_FIXED_PRIORITY_EN
            exp_ack = 2'b01;
`else
            exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("cont_ack", {30'b0, req1_ack, req0_ack}, {30'b0, exp_ack});
            tick();
        end
        tick();
`ifdef REFLET_FPU_ARB_FIXED_PRIORITY_EN
        chk("cont_last_done", {30'b0, req1_done, req0_done}, 32'h1);
        chk("cont_last_result", req0_result, 32'h40700000);
`else
        chk("cont_last_done", {30'b0, req1_done, req0_done}, 32'h2);
        chk("cont_last_result", req1_result, 32'h40000000);
`endif
        req0_valid = 0; req1_valid = 0;
        tick();

        // Timeout on req0 with an undefined opcode
        req0_valid = 1; req0_opcode = OPP_BAD; req0_in1 = 32'h0; req0_in2 = 32'h0;
        #1;
        chk("to_ack0", {30'b0, req1_ack, req0_ack}, 32'h1);
        tick();
        req0_valid = 0;
        repeat (63) tick();
        chk("to_before", {30'b0, au_enable, req0_done}, 32'h2);
        tick();
        chk("to_done", {30'b0, req0_timeout, req0_done}, 32'h3);
        chk("to_result", req0_result, 32'h0);
        chk("to_drain_en", {31'b0, au_enable}, 32'h0);
        tick();
        chk("to_idle", {30'b0, req0_timeout, req0_done}, 32'h0);

        // Reset in the middle of a multiply
        req0_valid = 1; req0_opcode = OPP_MUL; req0_in1 = 32'h40000000; req0_in2 = 32'h40400000;
        tick();
        req0_valid = 0;
        tick();
        chk("rstmid_en_before", {31'b0, au_enable}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_en_async", {31'b0, au_enable}, 32'h0);
        chk("rstmid_opcode", {26'b0, au_opcode}, 32'h0);
        tick();
        tick();
        chk("rstmid_no_done", {31'b0, req0_done}, 32'h0);
        reset = 1'b1;
        tick();
        chk("rstmid_no_done2", {31'b0, req0_done}, 32'h0);
        req0_valid = 1; req0_opcode = OPP_ADD; req0_in1 = 32'h3FC00000; req0_in2 = 32'h40100000;
        #1;
        chk("rstmid_ack", {30'b0, req1_ack, req0_ack}, 32'h1);
        tick();
        req0_valid = 0;
        tick();
        chk("rstmid_add_done", {30'b0, req0_timeout, req0_done}, 32'h1);
        chk("rstmid_add_result", req0_result, 32'h40700000);
        tick();

        // Ready coinciding with the last allowed cycle (timeout_cycles=3)
        c_valid = 1; c_opcode = OPP_MUL;
        #1;
        chk("co_ack", {31'b0, c0_ack}, 32'h1);
        tick();
        c_valid = 0;
        tick();
        tick();
        chk("co_ready", {30'b0, c_ready, c0_done}, 32'h2);
        tick();
        chk("co_done", {30'b0, c0_timeout, c0_done}, 32'h1);
        chk("co_result", c0_result, 32'h12345678);
        tick();

        // Short timeout on the same instance
        c_valid = 1; c_opcode = OPP_BAD;
        tick();
        c_valid = 0;
        tick();
        tick();
        chk("co_to_before", {31'b0, c0_done}, 32'h0);
        tick();
        chk("co_to_done", {30'b0, c0_timeout, c0_done}, 32'h3);
        chk("co_to_result", c0_result, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reflet_float_au_arbiter.md
Name: reflet_float_au_arbiter

Overview:
Shares one reflet_float_au instance between two requesters (for example the CPU-side FPU front end and a vector/DMA engine).
- Arbitrates between the requesters and latches the winner's opcode and operands.
- Holds the arithmetic unit's enable high until it reports ready, then deasserts enable for one cycle so the multi-cycle primitives restart cleanly.
- Returns the result with a done pulse, and aborts any operation whose ready never arrives (timeout).

Parameters:
float_size, 32, width of every float operand/result.
timeout_cycles, 64, maximum RUN cycles before abort; legal range 1..65535.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
reqN_valid  input  1  (N=0,1) request pending; held until acked.
reqN_opcode  input  6  (N=0,1) `OPP_* code from reflet_fpu.vh.
reqN_in1, reqN_in2, reqN_in3  input  float_size  (N=0,1) operands.
reqN_ack  output  1  (N=0,1) combinational; request accepted on this edge.
reqN_done  output  1  (N=0,1) one-cycle pulse; result valid.
reqN_timeout  output  1  (N=0,1) qualifies reqN_done; op aborted.
reqN_result  output  float_size  (N=0,1) result register, held until next done for N.
au_enable  output  1  to arithmetic unit enable.
au_opcode  output  6  to arithmetic unit opcode.
au_in1, au_in2, au_in3  output  float_size  to arithmetic unit flt_in1..3.
au_ready  input  1  from arithmetic unit ready.
au_out  input  float_size  from arithmetic unit flt_out.

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately, including mid-operation):
  - State IDLE; au_enable=0; au_opcode and au_in* = 0.
  - All reqN_done, reqN_timeout and reqN_result = 0; last_grant=1 (so req0 wins the first tie); timeout counter = 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - grant = the single valid requester; if both are valid, the one not equal to last_grant.
  - reqN_ack = (state==IDLE) && grant==N && reqN_valid.
  - On an acking edge: latch opcode/in1..3 into the au_* registers, set owner=N and last_grant=N, clear the counter, go to RUN.
- RUN:
  - au_enable=1 and au_* are stable.
  - Counter increments each RUN cycle.
  - If au_ready=1 at an edge: reqN_result<=au_out for the owner, done pulses in the following cycle, go to DRAIN.
  - Else, if the counter reaches timeout_cycles-1: result<=0, done and timeout pulse in the following cycle, go to DRAIN.
  - If au_ready and timeout coincide on the same edge, au_ready wins (no timeout).
- DRAIN:
  - au_enable=0 for exactly one cycle; reqN_done (and reqN_timeout if aborted) is high for that cycle.
  - Next edge goes to IDLE. No ack is possible in DRAIN.
- Latency:
  - Acceptance edge to done is (cycles until au_ready)+1.
  - Add/sub (combinational ready) gives done in the second cycle after acceptance.
  - Back-to-back issue rate is one op per (AU latency + 2) cycles.
- Requesters:
  - opcode/operands must stay stable while valid=1 and ack=0.
  - A requester may drop valid without ack (withdraw).
  - valid high again after done is treated as a new request.
- Only one op is ever outstanding; done/timeout are never asserted for both N in the same cycle.

Optional Feature:
REFLET_FPU_ARB_FIXED_PRIORITY_EN:
- Defined: req0 always wins when both requesters are valid; last_grant is not used for tie-breaking.
- Undefined: round-robin as described in Behaviour.
- All other behaviour is identical with and without the macro.

Test Plan:
- Add: req0 `OPP_ADD, in1=0x3FC00000, in2=0x40100000 -> req0_ack on the first edge, req0_done 2 cycles later, req0_result=0x40700000, timeout=0, au_enable low during the done cycle.
- Multiply: req1 `OPP_MUL, in1=0x40000000, in2=0x40400000 -> au_enable held until au_ready, req1_result=0x40C00000 one cycle after ready; req0 outputs unchanged.
- Contention: both valid continuously with add ops -> acks alternate req0, req1, req0, req1; with REFLET_FPU_ARB_FIXED_PRIORITY_EN -> req0 acked every time until req0_valid drops.
- Timeout: req0 with an undefined opcode 0x3F (au_ready never rises) -> req0_done and req0_timeout high exactly 64 cycles after acceptance, req0_result=0x00000000, then IDLE.
- Reset mid-operation: assert reset low during RUN of a mult -> au_enable=0 immediately without waiting for a clock edge; no done pulse; after release, a new add request completes normally.
- Coincidence: timeout_cycles=3 with an AU model asserting au_ready in RUN cycle 3 -> done with timeout=0 and result=au_out.
